// File: rtl/pingpong_frame_ram.sv
// pingpong_frame_ram: double-buffered pixel RAM, sequential capture into one bank, random reads from the other.
// Optional PPRAM_DROP_CNT_EN adds o_Drop_Cnt, a saturating count of writes dropped while waiting for a swap.
module pingpong_frame_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 20000,
    parameter int ADDR_W = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_Wr_Sof,
    input  logic              i_Wr_Eof,
    input  logic              i_Wr_Valid,
    input  logic [DATA_W-1:0] i_Wr_Data,
    output logic              o_Wr_Ready,
    input  logic              i_Rd_En,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [DATA_W-1:0] o_Rd_Data,
    output logic              o_Rd_Valid,
    input  logic              i_Rd_Swap,
    output logic              o_Swap,
    output logic              o_Frame_Valid,
    output logic              o_Wr_Bank
`ifdef PPRAM_DROP_CNT_EN
    ,
    output logic [15:0]       o_Drop_Cnt
`endif
);
    localparam logic FILL      = 1'b0;
    localparam logic WAIT_SWAP = 1'b1;

    logic              state;
    logic              wbank;
    logic              wr;
    logic              close;
    logic              swap_take;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    assign o_Wr_Ready = state == FILL;
    assign o_Wr_Bank  = wbank;

    // Sof rewinds the pointer in the same cycle, so a concurrent pixel lands at 0.
    always_comb begin
        wr        = state == FILL && i_Wr_Valid;
        waddr     = i_Wr_Sof ? '0 : wptr;
        close     = (wr && waddr == ADDR_W'(DEPTH - 1)) ||
                    (state == FILL && i_Wr_Eof && (wr || waddr != '0));
        swap_take = state == WAIT_SWAP && i_Rd_Swap;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= FILL;
            wbank         <= 1'b0;
            wptr          <= '0;
            o_Swap        <= 1'b0;
            o_Frame_Valid <= 1'b0;
            o_Rd_Valid    <= 1'b0;
            o_Rd_Data     <= '0;
        end else begin
            o_Swap     <= swap_take;
            o_Rd_Valid <= i_Rd_En;
            if (swap_take) begin
                wbank         <= ~wbank;
                state         <= FILL;
                o_Frame_Valid <= 1'b1;
            end else if (close) begin
                state <= WAIT_SWAP;
                wptr  <= '0;
            end else if (state == FILL) begin
                wptr <= wr ? waddr + 1'b1 : waddr;
            end
            // Read bank is the complement of the write bank at this edge.
            if (i_Rd_En)
                o_Rd_Data <= i_Rd_Addr < ADDR_W'(DEPTH) ?
                             (wbank ? mem0[i_Rd_Addr] : mem1[i_Rd_Addr]) : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) begin
            if (wbank)
                mem1[waddr] <= i_Wr_Data;
            else
                mem0[waddr] <= i_Wr_Data;
        end
    end

`ifdef PPRAM_DROP_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_Drop_Cnt <= '0;
        else if (swap_take)
            o_Drop_Cnt <= '0;
        else if (state == WAIT_SWAP && i_Wr_Valid && o_Drop_Cnt != 16'hFFFF)
            o_Drop_Cnt <= o_Drop_Cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pingpong_frame_ram.sv
// tb_pingpong_frame_ram: table vectors, hand sequences and random traffic checked against a frame-level model.
module tb_pingpong_frame_ram;
    localparam int DEPTH = 20000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_Wr_Sof = 1'b0, i_Wr_Eof = 1'b0, i_Wr_Valid = 1'b0;
    logic [7:0]  i_Wr_Data = '0;
    logic        i_Rd_En = 1'b0;
    logic [14:0] i_Rd_Addr = '0;
    logic        i_Rd_Swap = 1'b0;
    logic        o_Wr_Ready, o_Rd_Valid, o_Swap, o_Frame_Valid, o_Wr_Bank;
    logic [7:0]  o_Rd_Data;
`ifdef PPRAM_DROP_CNT_EN
    logic [15:0] o_Drop_Cnt;
`endif

    always #5 i_clk = ~i_clk;

    pingpong_frame_ram dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_Wr_Sof(i_Wr_Sof), .i_Wr_Eof(i_Wr_Eof), .i_Wr_Valid(i_Wr_Valid), .i_Wr_Data(i_Wr_Data),
        .o_Wr_Ready(o_Wr_Ready), .i_Rd_En(i_Rd_En), .i_Rd_Addr(i_Rd_Addr), .o_Rd_Data(o_Rd_Data),
        .o_Rd_Valid(o_Rd_Valid), .i_Rd_Swap(i_Rd_Swap), .o_Swap(o_Swap),
        .o_Frame_Valid(o_Frame_Valid), .o_Wr_Bank(o_Wr_Bank)
`ifdef PPRAM_DROP_CNT_EN
        , .o_Drop_Cnt(o_Drop_Cnt)
`endif
    );

    typedef struct {
        logic        sof, eof, vld;
        logic [7:0]  data;
        logic        rd_en;
        logic [14:0] addr;
        logic        swap;
        logic        ready, bank, swp, rvalid;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl [13];

    // Frame-level model: a frame is a list of pixels filling one bank; a full or closed frame waits for a swap.
    logic [7:0] m_mem [2][DEPTH];
    int   m_cnt, m_drop;
    bit   m_full, m_bank, m_fv, m_swap, m_rvalid;
    logic [7:0] m_rdata;
    int   total = 0, passed = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else begin
            fails++;
            if (fails <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function void model_reset();
        m_cnt = 0; m_drop = 0; m_full = 0; m_bank = 0; m_fv = 0; m_swap = 0; m_rvalid = 0; m_rdata = '0;
    endfunction

    function void model_step();
        m_rvalid = i_Rd_En;
        if (i_Rd_En) m_rdata = (int'(i_Rd_Addr) < DEPTH) ? m_mem[!m_bank][i_Rd_Addr] : 8'h00;
        m_swap = 0;
        if (!m_full) begin
            if (i_Wr_Sof) m_cnt = 0;
            if (i_Wr_Valid) begin
                m_mem[m_bank][m_cnt] = i_Wr_Data;
                m_cnt++;
            end
            if (m_cnt == DEPTH || (i_Wr_Eof && m_cnt > 0)) begin
                m_full = 1;
                m_cnt = 0;
            end
        end else begin
            if (i_Wr_Valid && m_drop < 65535) m_drop++;
            if (i_Rd_Swap) begin
                m_bank = !m_bank; m_full = 0; m_fv = 1; m_swap = 1; m_drop = 0;
            end
        end
    endfunction

    task automatic step(input logic sof, eof, vld, input logic [7:0] data,
                        input logic rd_en, input logic [14:0] addr, input logic swap);
        i_Wr_Sof = sof; i_Wr_Eof = eof; i_Wr_Valid = vld; i_Wr_Data = data;
        i_Rd_En = rd_en; i_Rd_Addr = addr; i_Rd_Swap = swap;
        @(posedge i_clk);
        model_step();
        #1;
        chk("model", {o_Wr_Ready, o_Wr_Bank, o_Swap, o_Frame_Valid, o_Rd_Valid, o_Rd_Data},
                     {!m_full, m_bank, m_swap, m_fv, m_rvalid, m_rdata});
`ifdef PPRAM_DROP_CNT_EN
        chk("drop_cnt", o_Drop_Cnt, m_drop);
`endif
    endtask

    task automatic do_reset(input string name);
        i_Wr_Sof = 0; i_Wr_Eof = 0; i_Wr_Valid = 0; i_Rd_En = 0; i_Rd_Swap = 0;
        i_rst_n = 1'b0;
        #2;
        model_reset();
        chk(name, {o_Wr_Ready, o_Wr_Bank, o_Swap, o_Frame_Valid, o_Rd_Valid, o_Rd_Data}, 13'h1000);
`ifdef PPRAM_DROP_CNT_EN
        chk({name, "_drop"}, o_Drop_Cnt, 0);
`endif
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 1, 8'hA0, 0, 0,  0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 0, 1, 8'hA1, 0, 0,  0, 1, 0, 0, 0, 8'h00};
        tbl[2]  = '{0, 0, 1, 8'hA2, 0, 0,  0, 1, 0, 0, 0, 8'h00};
        tbl[3]  = '{0, 0, 1, 8'hA3, 0, 0,  0, 1, 0, 0, 0, 8'h00};
        tbl[4]  = '{0, 1, 1, 8'hA4, 0, 0,  0, 0, 0, 0, 0, 8'h00};
        tbl[5]  = '{0, 0, 0, 8'h00, 1, 2,  0, 0, 0, 0, 1, 8'h0E};
        tbl[6]  = '{0, 0, 0, 8'h00, 1, 5,  1, 1, 1, 1, 1, 8'h23};
        tbl[7]  = '{0, 0, 0, 8'h00, 1, 0,  0, 1, 1, 0, 1, 8'hA0};
        tbl[8]  = '{0, 0, 0, 8'h00, 1, 4,  0, 1, 1, 0, 1, 8'hA4};
        tbl[9]  = '{0, 0, 0, 8'h00, 1, 5,  0, 1, 1, 0, 1, 8'h05};
        tbl[10] = '{0, 0, 0, 8'h00, 0, 0,  0, 1, 1, 0, 0, 8'h00};
        tbl[11] = '{0, 1, 0, 8'h00, 0, 0,  0, 1, 1, 0, 0, 8'h00};
        tbl[12] = '{0, 0, 0, 8'h00, 0, 0,  1, 1, 1, 0, 0, 8'h00};

        do_reset("reset");

        for (int i = 0; i < DEPTH; i++) step(i == 0, 0, 1, i[7:0], 0, 0, 0);
        chk("full_frame_ready_low", o_Wr_Ready, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("first_swap", {o_Swap, o_Wr_Bank, o_Frame_Valid}, 3'b111);
        step(0, 0, 0, 0, 1, 300, 0);
        chk("rd300", {o_Rd_Valid, o_Rd_Data}, {1'b1, 8'h2C});

        for (int i = 0; i < DEPTH - 1; i++) step(i == 0, 0, 1, 8'(i * 7), 0, 0, 0);
        step(0, 0, 1, 8'((DEPTH - 1) * 7), 0, 0, 1);
        chk("final_wr_with_swap", {o_Wr_Ready, o_Swap, o_Wr_Bank}, 3'b001);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("swap_released", {o_Wr_Ready, o_Swap, o_Wr_Bank}, 3'b001);
        repeat (10) step(0, 0, 1, 8'hFF, 0, 0, 0);
`ifdef PPRAM_DROP_CNT_EN
        chk("drop10", o_Drop_Cnt, 10);
`endif
        step(0, 0, 0, 0, 1, 300, 1);
        chk("read_in_swap_cycle", {o_Swap, o_Wr_Bank, o_Rd_Valid, o_Rd_Data}, {1'b1, 1'b0, 1'b1, 8'h2C});
`ifdef PPRAM_DROP_CNT_EN
        chk("drop_cleared", o_Drop_Cnt, 0);
`endif
        step(0, 0, 0, 0, 1, 20000, 0);
        chk("rd_out_of_range", {o_Rd_Valid, o_Rd_Data}, {1'b1, 8'h00});
        step(0, 0, 0, 0, 1, 300, 0);
        chk("rd_bank1_300", {o_Rd_Valid, o_Rd_Data}, {1'b1, 8'h34});
        step(0, 0, 0, 0, 1, 19999, 0);
        chk("dropped_data_absent", {o_Rd_Valid, o_Rd_Data}, {1'b1, 8'hD9});

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].sof, tbl[i].eof, tbl[i].vld, tbl[i].data, tbl[i].rd_en, tbl[i].addr, tbl[i].swap);
            chk($sformatf("tbl%0d", i),
                {o_Wr_Ready, o_Wr_Bank, o_Swap, o_Rd_Valid, tbl[i].rvalid ? o_Rd_Data : 8'h00},
                {tbl[i].ready, tbl[i].bank, tbl[i].swp, tbl[i].rvalid, tbl[i].rdata});
        end

        repeat (3000) begin
            logic [14:0] a;
            a = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(DEPTH, 32767)) : 15'($urandom_range(0, DEPTH - 1));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
                 8'($urandom), 1'($urandom_range(0, 1)), a, $urandom_range(0, 7) == 0);
        end

        do_reset("reset_again");
        for (int i = 0; i < 1234; i++) step(i == 0, 0, 1, 8'h11, 0, 0, 0);
        do_reset("reset_mid_frame");
        step(0, 0, 1, 8'h5A, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("post_reset_swap_bank", o_Wr_Bank, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("post_reset_addr0", {o_Rd_Valid, o_Rd_Data}, {1'b1, 8'h5A});
        step(0, 0, 0, 0, 1, 1, 0);
        chk("post_reset_addr1", {o_Rd_Valid, o_Rd_Data}, {1'b1, 8'h11});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pingpong_frame_ram.md
Name: pingpong_frame_ram

Overview:
Parametrised double-buffered (ping-pong) pixel RAM for the camera path. It replaces the single-bank 8-bit/20k RAM with two banks:
- The camera-capture side fills one bank sequentially, using an auto-incrementing address.
- The display/processing side randomly reads the other, completed bank.
- Banks swap only on a reader-side swap request once the write bank is complete, so the reader never sees a torn frame.

Parameters:
DATA_W, 8, pixel width in bits
DEPTH, 20000, pixels per bank (frame size)
ADDR_W, 15, address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_Wr_Sof  input  1  write start-of-frame pulse; resets write pointer
i_Wr_Eof  input  1  write end-of-frame pulse; closes a short frame
i_Wr_Valid  input  1  write data valid
i_Wr_Data  input  DATA_W  pixel to write
o_Wr_Ready  output  1  high when writes are accepted (state FILL)
i_Rd_En  input  1  read strobe
i_Rd_Addr  input  ADDR_W  read address within the read bank
o_Rd_Data  output  DATA_W  registered read data
o_Rd_Valid  output  1  one-cycle pulse, o_Rd_Data updated
i_Rd_Swap  input  1  reader requests swap (level, sampled each cycle)
o_Swap  output  1  one-cycle pulse on the cycle after a swap is taken
o_Frame_Valid  output  1  sticky; high once the first frame has been swapped in
o_Wr_Bank  output  1  current write bank index; read bank = ~o_Wr_Bank

Behaviour:
- Reset (async, i_rst_n=0):
  - wbank=0, state=FILL, wptr=0.
  - o_Rd_Data=0, o_Rd_Valid=0, o_Swap=0, o_Frame_Valid=0, o_Wr_Ready=1 (follows state).
  - Memory contents are not reset.
- Storage: two arrays of DEPTH x DATA_W; no combinational read path.
- States: FILL, WAIT_SWAP.
- FILL:
  - o_Wr_Ready=1.
  - i_Wr_Sof sets wptr=0. If i_Wr_Valid is high in the same cycle, the pixel goes to address 0 and wptr becomes 1.
  - i_Wr_Valid writes mem[wbank][wptr], then wptr++.
  - An accepted write at wptr==DEPTH-1 commits, sets wptr=0 and moves to WAIT_SWAP.
  - i_Wr_Eof with wptr>0 (after any same-cycle write) sets wptr=0 and moves to WAIT_SWAP.
  - i_Wr_Eof with wptr==0 and no write is ignored.
  - i_Rd_Swap is ignored in FILL.
- WAIT_SWAP:
  - o_Wr_Ready=0; i_Wr_Valid, i_Wr_Sof and i_Wr_Eof are ignored and data is dropped.
  - When i_Rd_Swap=1: wbank toggles, state returns to FILL, o_Frame_Valid is set to 1, and o_Swap pulses high on the next cycle.
- Simultaneous final write and i_Rd_Swap in FILL:
  - The write commits and the state enters WAIT_SWAP.
  - The swap is taken on the next cycle only if i_Rd_Swap is still high.
- Read:
  - i_Rd_En=1 latches o_Rd_Data <= mem[~wbank][i_Rd_Addr] and pulses o_Rd_Valid the next cycle (latency 1).
  - The bank is the one selected at the sampling edge, so a read in the swap cycle uses the pre-swap read bank.
  - i_Rd_Addr >= DEPTH returns 0, with o_Rd_Valid still pulsed.
  - i_Rd_En=0 holds o_Rd_Data and drives o_Rd_Valid=0.
- Read and write never collide: they always target opposite banks.
- Reset mid-frame discards pointer and state; the next frame starts in bank 0.

Optional Feature:
Macro PPRAM_DROP_CNT_EN.
- Defined: adds output o_Drop_Cnt [15:0].
  - Increments on every i_Wr_Valid cycle while in WAIT_SWAP; saturates at 16'hFFFF.
  - Cleared by reset and on each swap.
- Undefined: no port and no counter logic; dropped writes are silent.

Test Plan:
- Reset, Sof, then 20000 valid writes (data = addr[7:0]) -> o_Wr_Ready falls after the final write; i_Rd_Swap=1 -> o_Swap pulses, o_Wr_Bank=1, o_Frame_Valid=1; read addr 300 -> o_Rd_Data=8'h2C one cycle later.
- In WAIT_SWAP, 10 valid writes of 8'hFF, then swap -> read bank data unchanged; with the macro defined, o_Drop_Cnt=10 before the swap and 0 after.
- Sof, 5 writes, Eof -> WAIT_SWAP; swap -> addresses 0-4 read the new data, address 5 reads prior bank content.
- Final write and i_Rd_Swap in the same cycle, swap held for 1 cycle only -> no swap, o_Wr_Bank unchanged; swap reasserted -> swap taken.
- Read in the swap cycle -> returns pre-swap bank data; read addr 20000 -> o_Rd_Data=0, o_Rd_Valid=1.
- i_rst_n low mid-frame (wptr=1234) -> all outputs 0, o_Wr_Bank=0, o_Wr_Ready=1; next write lands at addr 0.
